// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with a one-word holding buffer.
// The shifter drains WIDTH-bit words one bit per valid/ready transfer. While a
// frame is shifting, the next word parks in the holding register. A word
// offered on the last-bit transfer bypasses the holding register, so frames
// follow each other with no idle cycle.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_data,
    output logic             ser_first,
    output logic             ser_last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic accept_s;
    logic xfer_s;
    logic last_xfer_s;

    // Move the shifter one position toward the bit that drives ser_data.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r = {v[WIDTH-2:0], 1'b0};
        end else begin
            r = {1'b0, v[WIDTH-1:1]};
        end
        return r;
    endfunction

    assign accept_s    = load_valid && load_ready;
    assign xfer_s      = ser_valid && ser_ready;
    assign last_xfer_s = xfer_s && (cnt_q == CNT_LAST);

    assign load_ready = !hold_full_q;
    assign ser_valid  = (state_q == ST_SHIFT);
    assign ser_data   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign ser_first  = ser_valid && (cnt_q == CNT_ZERO);
    assign ser_last   = ser_valid && (cnt_q == CNT_LAST);

    // State and datapath registers; reset discards both in-flight and held words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= {WIDTH{1'b0}};
            cnt_q       <= CNT_ZERO;
            hold_q      <= {WIDTH{1'b0}};
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Next-state logic: load, shift, reload from hold or bypass, and holding-buffer fill.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    shreg_d = load_data;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_xfer_s) begin
                    cnt_d = CNT_ZERO;
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept_s) begin
                        shreg_d = load_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (xfer_s) begin
                    shreg_d = shift_out(shreg_q);
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    state_d = ST_SHIFT;
                end
                // A word arriving while not on the last transfer waits in hold.
                if (accept_s && !last_xfer_s) begin
                    hold_d      = load_data;
                    hold_full_d = 1'b1;
                end else begin
                    hold_full_d = hold_full_d;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = CNT_ZERO;
                hold_full_d = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in serial-out transmitter that drains WIDTH-bit words written by an upstream register stage and sends them one bit per transfer on a valid/ready serial link. It is the read/unload end of the parallel register path. A one-word holding buffer lets the next word be accepted while the current one shifts, so consecutive frames go out back-to-back with no idle cycle.

## Interface
- WIDTH, 8, word width in bits; legal values are WIDTH >= 2.
- MSB_FIRST, 1, 1 = send bit WIDTH-1 first; 0 = send bit 0 first.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  upstream word available.
- load_ready  out  1  block can accept a word (holding buffer empty).
- load_data  in  WIDTH  word to transmit.
- ser_valid  out  1  ser_data carries a valid bit.
- ser_ready  in  1  downstream accepts the bit this cycle.
- ser_data  out  1  current serial bit.
- ser_first  out  1  current bit is bit 0 of the frame.
- ser_last  out  1  current bit is bit WIDTH-1 of the frame.

## Operation
- State: shifter shreg[WIDTH-1:0], bit counter cnt[$clog2(WIDTH)-1:0], active flag, holding register hold[WIDTH-1:0] and hold_full flag.
- FSM has two states.
  - IDLE: active=0.
  - SHIFT: active=1.
- Word accept: load_valid && load_ready. Bit transfer: ser_valid && ser_ready.
- load_ready = !hold_full (combinational). It never depends on load_valid.
- Accept in IDLE: the word goes straight into shreg, cnt=0, next state is SHIFT, and hold stays empty.
- Accept in SHIFT with no last-bit transfer in the same cycle: the word goes into hold and hold_full=1.
- Bit transfer with cnt < WIDTH-1: shreg shifts toward the output end and cnt increments.
- Bit transfer with cnt == WIDTH-1 (last bit):
  - If hold_full: shreg <= hold, hold_full=0, cnt=0, stay in SHIFT.
  - Else, if a word is accepted in the same cycle: shreg <= load_data, cnt=0, stay in SHIFT (bypass).
  - Else: cnt=0, go to IDLE.
- Outputs:
  - ser_valid = active.
  - ser_data = shreg[WIDTH-1] when MSB_FIRST, otherwise shreg[0].
  - ser_first = active && cnt==0.
  - ser_last = active && cnt==WIDTH-1.
- Stall: while ser_valid && !ser_ready, shreg, cnt, ser_data, ser_first and ser_last hold stable. A word may still be accepted into hold during a stall.
- Reset (async assert, sync deassert handled upstream):
  - shreg, hold, cnt, hold_full and active are cleared.
  - Outputs go to ser_valid=0, ser_data=0, ser_first=0, ser_last=0, load_ready=1.
  - Reset mid-frame discards both the in-flight word and the held word. No partial frame resumes.

## Timing
- Accept latency: a word accepted at edge N into an IDLE block drives ser_valid=1 with its first bit from edge N until the next transfer edge.
- Frame length: exactly WIDTH transfer cycles. With ser_ready tied high, a frame occupies cycles N+1..N+WIDTH.
- Back-to-back frames: if hold_full, or bypass occurs at the last-bit transfer, the next frame's first bit appears the cycle immediately after the last bit. ser_valid stays continuously high.
- load_ready falls the cycle after a word is captured into hold. It rises the cycle after the hold word moves into shreg.
- Throughput: at most one word per WIDTH cycles sustained, plus one buffered word.

## Test plan
- Single frame, MSB_FIRST=1, WIDTH=8, load_data=8'hA5, ser_ready=1:
  - ser_data sequence is 1,0,1,0,0,1,0,1 on the 8 cycles after accept.
  - ser_first is high on bit 1 only; ser_last is high on bit 8 only.
  - ser_valid returns to 0 on the 9th cycle.
- Back-to-back: 8'hA5 accepted in IDLE, then 8'h3C presented on the next cycle:
  - 8'h3C is captured into hold and load_ready=0 for 7 cycles.
  - 16 contiguous ser_valid cycles carry A5 then 3C, with ser_first at bits 1 and 9.
- Bypass: present 8'h0F exactly on the last-bit cycle of a frame while hold is empty. The new frame follows with no gap and load_ready stays 1.
- Backpressure: drop ser_ready for 3 cycles at bit 4 of 8'hA5:
  - ser_data, ser_first and ser_last are frozen during the stall.
  - The full bit sequence is unchanged, and the frame ends 3 cycles later.
- LSB order: MSB_FIRST=0, load_data=8'h01. Bits are 1,0,0,0,0,0,0,0.
- Reset mid-frame: assert rst_n=0 asynchronously at bit 5 with hold full:
  - All outputs go to their reset values immediately, with no clock edge needed.
  - After release, load_ready=1, ser_valid=0, and a new 8'hC3 transmits correctly.
